bfp16_ws_col_ctrl: RTL and testbench
====================================

Name: bfp16_ws_col_ctrl

Overview:
Sequencer for a DEPTH-deep BFP16 weight-stationary PE column.
- Collects DEPTH weights over a valid/ready stream, then shifts them into the column on contiguous ctrl=0 cycles.
- Streams LEN ifmap vectors in HOLD mode (ctrl=1), applying the per-PE input skew.
- Tags the column's psum output with a valid strobe and counts results. Signals done when the last result leaves the column.

Parameters:
DEPTH, 2, number of PEs in the column (≥2)
PE_LAT, 1, cycles from a PE's ifmap/psum input to its psum output in HOLD
LEN_W, 8, width of the vector-count field

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle job request; sampled only in IDLE
reload  in  1  sampled with start; 1 = load new weights, 0 = reuse resident weights
len  in  LEN_W  number of ifmap vectors in the job; sampled with start
w_valid  in  1  weight beat valid
w_ready  out  1  weight beat accepted when w_valid&w_ready
w_data  in  16  BFP16 weight; beat order is deepest PE first, PE0 last
x_valid  in  1  ifmap vector valid
x_ready  out  1  ifmap accepted when x_valid&x_ready
x_data  in  16*DEPTH  ifmap vector; PE0 lane is the top slice
pe_ctrl  out  1  column ctrl: 1 = HOLD/compute, 0 = weight shift
pe_weight  out  16  column weight input
pe_ifmap  out  16*DEPTH  skewed column ifmap input
col_out  in  16  column psum output
y_valid  out  1  col_out is a valid result this cycle; no backpressure
y_data  out  16  result (registered copy of col_out)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a job completes

Behaviour:
- Reset values: state=IDLE, pe_ctrl=1, pe_weight=0, pe_ifmap=0, w_ready=0, x_ready=0, y_valid=0, y_data=0, busy=0, done=0. Reset also clears the weight buffer, skew registers, valid pipe and counters.
- Reset mid-job aborts the job. Resident weights are then undefined; the next job must use reload=1.
- IDLE:
  - pe_ctrl=1, pe_ifmap=0.
  - start&reload → WFILL.
  - start&!reload → STREAM, or DONE if len==0.
  - start is ignored in all other states.
- WFILL:
  - w_ready=1; accepted beats fill an internal DEPTH×16 buffer in arrival order.
  - After the DEPTH-th accepted beat → WSHIFT next cycle.
  - Weight stalls (w_valid low) are tolerated; the column is not disturbed (pe_ctrl stays 1).
- WSHIFT:
  - Exactly DEPTH consecutive cycles with pe_ctrl=0; pe_weight = buffer[i] on cycle i.
  - pe_ifmap=0.
  - Then → STREAM, or DONE if len==0.
- STREAM:
  - pe_ctrl=1, x_ready=1 until len vectors are accepted.
  - An accepted vector's PE k lane reaches pe_ifmap lane k after k*PE_LAT cycles (PE0 lane undelayed).
  - A cycle with no accepted vector injects zero lanes and a valid-pipe 0.
  - After the len-th acceptance → DRAIN.
- DRAIN:
  - pe_ctrl=1, x_ready=0, zero lanes injected.
  - Wait until the result counter reaches len → DONE.
- Result timing: y_valid/y_data occur exactly DEPTH*PE_LAT+1 cycles after the accepting clock edge. The +1 is the output register. The valid pipe has length DEPTH*PE_LAT.
- Results are in acceptance order; y_data holds its last value when y_valid=0.
- DONE: done=1 for one cycle → IDLE. busy=0 in the same cycle as done? No: busy=1 in DONE and drops in IDLE.
- Counters: acceptance and result counters are LEN_W wide; len=2^LEN_W-1 must work without wrap.
- Simultaneous events: x_valid in WFILL/WSHIFT is not accepted (x_ready=0); w_valid outside WFILL is not accepted.

Decomposition:
- Shared package bfp16_pkg: BFP16 width constant (16), ctrl encodings (CTRL_HOLD=1, CTRL_SHIFT=0), and the controller state enum.
- One sub-module is natural: bfp16_skew_line (parameterised delay line delivering lane k delayed by k*PE_LAT cycles, synchronous reset to zero). It is reused for the valid pipe with a single-bit width.

Test Plan:
- DEPTH=2, PE_LAT=1; reload=1, len=1, weights 0x4000 then 0x3F80, x_data={0x4000,0x3F80} → pe_ctrl=0 for exactly 2 cycles; then y_valid once with y_data=0x4080 (1·2+2·1=4.0); done one cycle later.
- Weight stalls: w_valid low for 3 cycles between beats → pe_ctrl stays 1 throughout WFILL; WSHIFT is still 2 contiguous cycles; same 0x4080 result.
- Reuse: second job reload=0, len=3, vectors {0x3F80,0x3F80} ×3 with one x_valid bubble → no pe_ctrl=0 cycle; exactly 3 y_valid pulses of 0x4040 (3.0), with a one-cycle gap matching the bubble.
- len=0 with reload=1 → weights shifted, no y_valid, done pulse directly after WSHIFT.
- Reset asserted in DRAIN → next cycle all outputs at reset values, no further y_valid; start with reload=1 is then accepted normally.
- start while busy → ignored; job counts and done count unchanged.

Source files
------------

// File: rtl/bfp16_pkg.sv
// rtl/bfp16_pkg.sv - shared BFP16 constants, column ctrl encodings and controller states
package bfp16_pkg;

  localparam int BFP16_W = 16;

  localparam logic CTRL_HOLD  = 1'b1;
  localparam logic CTRL_SHIFT = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WFILL,
    ST_WSHIFT,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_e;

endpackage

// File: rtl/bfp16_skew_line.sv
// rtl/bfp16_skew_line.sv - per-lane delay line, lane k delayed by (k+BASE)*LAT cycles
module bfp16_skew_line #(
  parameter int LANES = 2,
  parameter int W     = 16,
  parameter int LAT   = 1,
  parameter int BASE  = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [LANES*W-1:0] i_data,
  output logic [LANES*W-1:0] o_data
);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int D = (k + BASE) * LAT;
    if (D == 0) begin : g_pass
      assign o_data[k*W +: W] = i_data[k*W +: W];
    end else begin : g_dly
      logic [W-1:0] r_sh [D];
      // advance every stage of this lane by one cycle; reset flushes to zero
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int j = 0; j < D; j++) r_sh[j] <= '0;
        end else begin
          r_sh[0] <= i_data[k*W +: W];
          for (int j = 1; j < D; j++) r_sh[j] <= r_sh[j-1];
        end
      end
      assign o_data[k*W +: W] = r_sh[D-1];
    end
  end

endmodule

// File: rtl/bfp16_ws_col_ctrl.sv
// rtl/bfp16_ws_col_ctrl.sv - weight-stationary BFP16 PE column sequencer
module bfp16_ws_col_ctrl
  import bfp16_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int PE_LAT = 1,
  parameter int LEN_W  = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_reload,
  input  logic [LEN_W-1:0]           i_len,
  input  logic                       i_w_valid,
  output logic                       o_w_ready,
  input  logic [BFP16_W-1:0]         i_w_data,
  input  logic                       i_x_valid,
  output logic                       o_x_ready,
  input  logic [BFP16_W*DEPTH-1:0]   i_x_data,
  output logic                       o_pe_ctrl,
  output logic [BFP16_W-1:0]         o_pe_weight,
  output logic [BFP16_W*DEPTH-1:0]   o_pe_ifmap,
  input  logic [BFP16_W-1:0]         i_col_out,
  output logic                       o_y_valid,
  output logic [BFP16_W-1:0]         o_y_data,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int            IW   = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  ctrl_state_e              r_state, w_next;
  logic [LEN_W-1:0]         r_len, r_acc_cnt, r_res_cnt;
  logic [BFP16_W-1:0]       r_wbuf [DEPTH];
  logic [IW-1:0]            r_wcnt, r_scnt;
  logic                     w_w_acc, w_x_acc, w_vpipe_out, w_lanes_en;
  logic [BFP16_W*DEPTH-1:0] w_skew_in, w_skew_out;

  assign w_w_acc    = i_w_valid & o_w_ready;
  assign w_x_acc    = i_x_valid & o_x_ready;
  assign w_lanes_en = (r_state == ST_STREAM) || (r_state == ST_DRAIN);

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // next-state decode and per-state column/handshake outputs
  always_comb begin
    w_next      = r_state;
    o_w_ready   = 1'b0;
    o_x_ready   = 1'b0;
    o_pe_ctrl   = CTRL_HOLD;
    o_pe_weight = '0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          if (i_reload)            w_next = ST_WFILL;
          else if (i_len == '0)    w_next = ST_DONE;
          else                     w_next = ST_STREAM;
        end
      end
      ST_WFILL: begin
        o_w_ready = 1'b1;
        if (i_w_valid && (r_wcnt == LAST)) w_next = ST_WSHIFT;
      end
      ST_WSHIFT: begin
        o_pe_ctrl   = CTRL_SHIFT;
        o_pe_weight = r_wbuf[r_scnt];
        if (r_scnt == LAST) w_next = (r_len == '0) ? ST_DONE : ST_STREAM;
      end
      ST_STREAM: begin
        o_x_ready = 1'b1;
        if (i_x_valid && (r_acc_cnt == r_len - LEN_W'(1))) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_res_cnt == r_len) w_next = ST_DONE;
      end
      ST_DONE: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // job length capture plus beat, shift, acceptance and result counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len     <= '0;
      r_acc_cnt <= '0;
      r_res_cnt <= '0;
      r_wcnt    <= '0;
      r_scnt    <= '0;
    end else begin
      if ((r_state == ST_IDLE) && i_start) begin
        r_len     <= i_len;
        r_acc_cnt <= '0;
        r_res_cnt <= '0;
      end
      if (w_w_acc)               r_wcnt    <= (r_wcnt == LAST) ? '0 : r_wcnt + IW'(1);
      if (r_state == ST_WSHIFT)  r_scnt    <= (r_scnt == LAST) ? '0 : r_scnt + IW'(1);
      if (w_x_acc)               r_acc_cnt <= r_acc_cnt + LEN_W'(1);
      if (w_vpipe_out)           r_res_cnt <= r_res_cnt + LEN_W'(1);
    end
  end

  // weight buffer, filled in arrival order so entry 0 (deepest PE) shifts in first
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_wbuf[i] <= '0;
    end else if (w_w_acc) begin
      r_wbuf[r_wcnt] <= i_w_data;
    end
  end

  // result register: tag col_out when the matching valid emerges, hold otherwise
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_y_valid <= 1'b0;
      o_y_data  <= '0;
    end else begin
      o_y_valid <= w_vpipe_out;
      if (w_vpipe_out) o_y_data <= i_col_out;
    end
  end

  // skew line lane k carries PE k, which sits in the x_data/pe_ifmap slice counted from the top
  for (genvar k = 0; k < DEPTH; k++) begin : g_map
    assign w_skew_in[k*BFP16_W +: BFP16_W] =
      w_x_acc ? i_x_data[(DEPTH-1-k)*BFP16_W +: BFP16_W] : '0;
    assign o_pe_ifmap[(DEPTH-1-k)*BFP16_W +: BFP16_W] =
      w_lanes_en ? w_skew_out[k*BFP16_W +: BFP16_W] : '0;
  end

  bfp16_skew_line #(
    .LANES (DEPTH),
    .W     (BFP16_W),
    .LAT   (PE_LAT),
    .BASE  (0)
  ) u_ifmap_skew (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data (w_skew_in),
    .o_data (w_skew_out)
  );

  bfp16_skew_line #(
    .LANES (1),
    .W     (1),
    .LAT   (PE_LAT),
    .BASE  (DEPTH)
  ) u_valid_pipe (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data (w_x_acc),
    .o_data (w_vpipe_out)
  );

endmodule

// File: tb/tb_bfp16_ws_col_ctrl.sv
// tb/tb_bfp16_ws_col_ctrl.sv - directed bench for the BFP16 weight-stationary column sequencer
module tb_bfp16_ws_col_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, reload = 1'b0;
  logic [7:0]  len = '0;
  logic        w_valid = 1'b0, w_ready;
  logic [15:0] w_data = '0;
  logic        x_valid = 1'b0, x_ready;
  logic [31:0] x_data = '0;
  logic        pe_ctrl;
  logic [15:0] pe_weight;
  logic [31:0] pe_ifmap;
  logic [15:0] col_out;
  logic        y_valid;
  logic [15:0] y_data;
  logic        busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  bfp16_ws_col_ctrl #(.DEPTH(2), .PE_LAT(1), .LEN_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_reload(reload), .i_len(len),
    .i_w_valid(w_valid), .o_w_ready(w_ready), .i_w_data(w_data),
    .i_x_valid(x_valid), .o_x_ready(x_ready), .i_x_data(x_data),
    .o_pe_ctrl(pe_ctrl), .o_pe_weight(pe_weight), .o_pe_ifmap(pe_ifmap),
    .i_col_out(col_out), .o_y_valid(y_valid), .o_y_data(y_data),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  function automatic real bf2r(input logic [15:0] b);
    real m;
    int  e;
    if (b[14:0] == 15'd0) return 0.0;
    e = int'(b[14:7]) - 127;
    m = 1.0 + real'(b[6:0]) / 128.0;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2bf(input real r);
    int e;
    int mant;
    logic [7:0] ef;
    logic [6:0] mf;
    if (r <= 0.0) return 16'h0000;
    e = 0;
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0)  begin r = r * 2.0; e--; end
    mant = int'((r - 1.0) * 128.0);
    ef = 8'(e + 127);
    mf = 7'(mant);
    return {1'b0, ef, mf};
  endfunction

  // behavioural 2-PE column: weights shift PE0->PE1, HOLD computes registered psums
  real mw0 = 0.0, mw1 = 0.0, mp0 = 0.0, mp1 = 0.0;
  always @(posedge clk) begin
    if (pe_ctrl == 1'b0) begin
      mw1 <= mw0;
      mw0 <= bf2r(pe_weight);
    end else begin
      mp0 <= bf2r(pe_ifmap[31:16]) * mw0;
      mp1 <= mp0 + bf2r(pe_ifmap[15:0]) * mw1;
    end
  end
  always_comb col_out = r2bf(mp1);

  // event monitor sampled on the falling edge
  int          cyc = 0, n_shift = 0, n_burst = 0, n_y = 0, n_done = 0, n_acc = 0;
  int          last_shift_cyc = 0, done_cyc = 0, acc_cyc = 0;
  logic        prev_ctrl = 1'b1;
  logic [15:0] y_val [64];
  int          y_cyc [64];
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (!pe_ctrl) begin
        n_shift = n_shift + 1;
        last_shift_cyc = cyc;
        if (prev_ctrl) n_burst = n_burst + 1;
      end
      if (y_valid) begin
        y_val[n_y % 64] = y_data;
        y_cyc[n_y % 64] = cyc;
        n_y = n_y + 1;
      end
      if (done) begin n_done = n_done + 1; done_cyc = cyc; end
      if (x_valid && x_ready) begin n_acc = n_acc + 1; acc_cyc = cyc; end
    end
    prev_ctrl = pe_ctrl;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic rl, input logic [7:0] ln);
    start = 1'b1; reload = rl; len = ln;
    tick();
    start = 1'b0;
  endtask

  task automatic send_w(input logic [15:0] d, input int gap);
    int t = 0;
    repeat (gap) tick();
    w_valid = 1'b1; w_data = d;
    while (!w_ready && t < 50) begin tick(); t++; end
    n_tests++;
    if (t >= 50) begin n_fail++; $display("FAIL w_ready_timeout: waited %0d cycles, required < 50", t); end
    tick();
    w_valid = 1'b0;
  endtask

  task automatic send_x(input logic [31:0] d, input int gap);
    int t = 0;
    repeat (gap) tick();
    x_valid = 1'b1; x_data = d;
    while (!x_ready && t < 50) begin tick(); t++; end
    n_tests++;
    if (t >= 50) begin n_fail++; $display("FAIL x_ready_timeout: waited %0d cycles, required < 50", t); end
    tick();
    x_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    int s = n_done;
    while (n_done == s && t < 200) begin tick(); t++; end
    n_tests++;
    if (t >= 200) begin n_fail++; $display("FAIL done_timeout: waited %0d cycles, required < 200", t); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({pe_ctrl, w_ready, x_ready, y_valid, busy, done} !== 6'b100000) begin
      n_fail++; $display("FAIL reset_ctl: got %b required 100000", {pe_ctrl, w_ready, x_ready, y_valid, busy, done});
    end
    n_tests++;
    if (pe_weight !== 16'h0) begin n_fail++; $display("FAIL reset_weight: got %h required 0000", pe_weight); end
    n_tests++;
    if (pe_ifmap !== 32'h0) begin n_fail++; $display("FAIL reset_ifmap: got %h required 00000000", pe_ifmap); end
    n_tests++;
    if (y_data !== 16'h0) begin n_fail++; $display("FAIL reset_ydata: got %h required 0000", y_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int s_shift = n_shift, s_burst = n_burst, s_y = n_y, s_done = n_done;
    start_job(1'b1, 8'd1);
    n_tests++;
    if ({busy, w_ready, x_ready} !== 3'b110) begin
      n_fail++; $display("FAIL basic_wfill: got %b required 110", {busy, w_ready, x_ready});
    end
    send_w(16'h4000, 0);
    send_w(16'h3F80, 0);
    send_x(32'h4000_3F80, 0);
    wait_done();
    n_tests++;
    if (n_shift - s_shift !== 2) begin n_fail++; $display("FAIL basic_shift_cycles: got %0d required 2", n_shift - s_shift); end
    n_tests++;
    if (n_burst - s_burst !== 1) begin n_fail++; $display("FAIL basic_shift_bursts: got %0d required 1", n_burst - s_burst); end
    n_tests++;
    if (n_y - s_y !== 1) begin n_fail++; $display("FAIL basic_y_count: got %0d required 1", n_y - s_y); end
    n_tests++;
    if (y_val[(n_y-1) % 64] !== 16'h4080) begin n_fail++; $display("FAIL basic_y_data: got %h required 4080", y_val[(n_y-1) % 64]); end
    n_tests++;
    if (y_cyc[(n_y-1) % 64] - acc_cyc !== 3) begin
      n_fail++; $display("FAIL basic_latency: got %0d required 3", y_cyc[(n_y-1) % 64] - acc_cyc);
    end
    n_tests++;
    if (done_cyc - y_cyc[(n_y-1) % 64] !== 1) begin
      n_fail++; $display("FAIL basic_done_after_y: got %0d required 1", done_cyc - y_cyc[(n_y-1) % 64]);
    end
    n_tests++;
    if (n_done - s_done !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d required 1", n_done - s_done); end
    n_tests++;
    if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL basic_idle_after: got %b required 00", {busy, done}); end
  endtask

  task automatic test_wstall();
    int s_shift, s_burst, s_y = n_y;
    start_job(1'b1, 8'd1);
    s_shift = n_shift; s_burst = n_burst;
    send_w(16'h4000, 0);
    send_w(16'h3F80, 3);
    n_tests++;
    if (n_shift - s_shift !== 0) begin n_fail++; $display("FAIL wstall_ctrl_in_fill: got %0d shift cycles required 0", n_shift - s_shift); end
    send_x(32'h4000_3F80, 0);
    wait_done();
    n_tests++;
    if ((n_shift - s_shift !== 2) || (n_burst - s_burst !== 1)) begin
      n_fail++; $display("FAIL wstall_shift: got %0d cycles in %0d bursts required 2 in 1", n_shift - s_shift, n_burst - s_burst);
    end
    n_tests++;
    if ((n_y - s_y !== 1) || (y_val[(n_y-1) % 64] !== 16'h4080)) begin
      n_fail++; $display("FAIL wstall_result: got %0d results last %h required 1 of 4080", n_y - s_y, y_val[(n_y-1) % 64]);
    end
  endtask

  task automatic test_reuse();
    int s_shift = n_shift, s_y = n_y;
    start_job(1'b0, 8'd3);
    send_x(32'h3F80_3F80, 0);
    send_x(32'h3F80_3F80, 1);
    send_x(32'h3F80_3F80, 0);
    wait_done();
    n_tests++;
    if (n_shift - s_shift !== 0) begin n_fail++; $display("FAIL reuse_no_shift: got %0d required 0", n_shift - s_shift); end
    n_tests++;
    if (n_y - s_y !== 3) begin n_fail++; $display("FAIL reuse_y_count: got %0d required 3", n_y - s_y); end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (y_val[(s_y + i) % 64] !== 16'h4040) begin
        n_fail++; $display("FAIL reuse_y_data[%0d]: got %h required 4040", i, y_val[(s_y + i) % 64]);
      end
    end
    n_tests++;
    if ((y_cyc[(s_y+1) % 64] - y_cyc[s_y % 64] !== 2) || (y_cyc[(s_y+2) % 64] - y_cyc[(s_y+1) % 64] !== 1)) begin
      n_fail++; $display("FAIL reuse_gaps: got %0d,%0d required 2,1",
                         y_cyc[(s_y+1) % 64] - y_cyc[s_y % 64], y_cyc[(s_y+2) % 64] - y_cyc[(s_y+1) % 64]);
    end
  endtask

  task automatic test_len0();
    int s_shift = n_shift, s_y = n_y;
    start_job(1'b1, 8'd0);
    send_w(16'h4000, 0);
    send_w(16'h3F80, 0);
    wait_done();
    n_tests++;
    if (n_shift - s_shift !== 2) begin n_fail++; $display("FAIL len0_shift: got %0d required 2", n_shift - s_shift); end
    n_tests++;
    if (n_y - s_y !== 0) begin n_fail++; $display("FAIL len0_no_y: got %0d required 0", n_y - s_y); end
    n_tests++;
    if (done_cyc - last_shift_cyc !== 1) begin n_fail++; $display("FAIL len0_done_timing: got %0d required 1", done_cyc - last_shift_cyc); end
  endtask

  task automatic test_reset_drain();
    int s_y = n_y;
    start_job(1'b0, 8'd1);
    send_x(32'h4000_3F80, 0);
    rst = 1'b1;
    tick();
    n_tests++;
    if ({pe_ctrl, w_ready, x_ready, y_valid, busy, done, pe_weight, pe_ifmap} !== {6'b100000, 48'h0}) begin
      n_fail++; $display("FAIL rstdrain_outputs: got ctl %b w %h x %h required ctl 100000 w 0000 x 00000000",
                         {pe_ctrl, w_ready, x_ready, y_valid, busy, done}, pe_weight, pe_ifmap);
    end
    rst = 1'b0;
    repeat (6) tick();
    n_tests++;
    if (n_y - s_y !== 0) begin n_fail++; $display("FAIL rstdrain_no_y: got %0d required 0", n_y - s_y); end
    start_job(1'b1, 8'd1);
    send_w(16'h4000, 0);
    send_w(16'h3F80, 0);
    send_x(32'h4000_3F80, 0);
    wait_done();
    n_tests++;
    if ((n_y - s_y !== 1) || (y_val[(n_y-1) % 64] !== 16'h4080)) begin
      n_fail++; $display("FAIL rstdrain_rerun: got %0d results last %h required 1 of 4080", n_y - s_y, y_val[(n_y-1) % 64]);
    end
  endtask

  task automatic test_start_busy();
    int s_y = n_y, s_done = n_done, s_acc = n_acc;
    start_job(1'b1, 8'd1);
    start_job(1'b0, 8'd5);
    x_valid = 1'b1; x_data = 32'h4000_3F80;
    send_w(16'h4000, 0);
    send_w(16'h3F80, 0);
    n_tests++;
    if (n_acc - s_acc !== 0) begin n_fail++; $display("FAIL busy_x_in_weights: got %0d accepts required 0", n_acc - s_acc); end
    send_x(32'h4000_3F80, 0);
    start_job(1'b0, 8'd5);
    wait_done();
    repeat (5) tick();
    n_tests++;
    if ((n_done - s_done !== 1) || (n_acc - s_acc !== 1) || (n_y - s_y !== 1)) begin
      n_fail++; $display("FAIL busy_counts: got done %0d acc %0d y %0d required 1 1 1", n_done - s_done, n_acc - s_acc, n_y - s_y);
    end
    n_tests++;
    if (y_val[(n_y-1) % 64] !== 16'h4080) begin n_fail++; $display("FAIL busy_y_data: got %h required 4080", y_val[(n_y-1) % 64]); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle: got %b required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wstall();
    test_reuse();
    test_len0();
    test_reset_drain();
    test_start_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
